// File: rtl/param_updown_mod_counter_pkg.sv
// Shared encodings and parameter legality helper for param_updown_mod_counter.
package param_updown_mod_counter_pkg;

   // Direction encodings for the Up input.
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // True when WIDTH/MODULUS/RESET_VALUE describe a realisable counter.
   function automatic bit params_legal(input int unsigned width,
                                       input int unsigned modulus,
                                       input int unsigned reset_value);
      longint unsigned span;
      span = longint'(64'd1) << width;
      return (width >= 1) && (modulus >= 2) &&
             (longint'(modulus) <= span) && (reset_value < modulus);
   endfunction

endpackage

// File: rtl/param_updown_mod_counter_dff.sv
// Single-bit D flip-flop, rising edge, synchronous active-high reset to RST_VAL.
module dFlipFlopPosClkSynRstHigh #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic q_q;

   // Storage bit; reset is sampled on the clock edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) q_q <= RST_VAL;
      else       q_q <= d_i;
   end

   assign q_o = q_q;

endmodule

// File: rtl/param_updown_mod_counter.sv
// Synchronous up/down modulo counter with load, terminal count, wrap pulse and
// optional saturation. Next-state logic lives here; storage is per-bit flops.
module param_updown_mod_counter
   import param_updown_mod_counter_pkg::*;
#(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned MODULUS     = 16,
   parameter int unsigned RESET_VALUE = 0,
   parameter int unsigned SATURATE    = 0
) (
   input  logic             Clk,
   input  logic             Clr,
   input  logic             En,
   input  logic             Up,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadVal,
   output logic [WIDTH-1:0] count,
   output logic             Tc,
   output logic             Wrap
);

   localparam int unsigned CW = WIDTH + 1;
   localparam logic [WIDTH:0] MAX_EXT = CW'(MODULUS - 1);

   // Reject illegal parameter combinations at elaboration.
   if (!params_legal(WIDTH, MODULUS, RESET_VALUE)) begin : g_bad_params
      $error("param_updown_mod_counter: illegal WIDTH/MODULUS/RESET_VALUE");
   end

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic [WIDTH:0]   count_ext, load_ext;
   logic             at_max, at_zero;

   // Range-end detection in WIDTH+1 bits so MODULUS = 2^WIDTH compares cleanly.
   always_comb begin
      count_ext = {1'b0, count_q};
      load_ext  = {1'b0, LoadVal};
      at_max    = (count_ext == MAX_EXT);
      at_zero   = (count_ext == '0);
   end

   // Next count and wrap; Clr priority is applied by the flops' sync reset.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (Load) begin
         count_d = (load_ext <= MAX_EXT) ? LoadVal : WIDTH'(MAX_EXT);
      end else if (En) begin
         if (Up == DIR_UP) begin
            if (at_max) begin
               if (SATURATE == 0) begin
                  count_d = '0;
                  wrap_d  = 1'b1;
               end
            end else begin
               count_d = WIDTH'(count_ext + CW'(1));
            end
         end else begin
            if (at_zero) begin
               if (SATURATE == 0) begin
                  count_d = WIDTH'(MAX_EXT);
                  wrap_d  = 1'b1;
               end
            end else begin
               count_d = WIDTH'(count_ext - CW'(1));
            end
         end
      end
   end

   // Count register, one flop per bit with its own reset value.
   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_count_ff
      dFlipFlopPosClkSynRstHigh #(
         .RST_VAL(1'((RESET_VALUE >> i) & 1))
      ) u_ff (
         .clk_i(Clk),
         .rst_i(Clr),
         .d_i  (count_d[i]),
         .q_o  (count_q[i])
      );
   end

   // Wrap pulse register.
   dFlipFlopPosClkSynRstHigh #(
      .RST_VAL(1'b0)
   ) u_wrap_ff (
      .clk_i(Clk),
      .rst_i(Clr),
      .d_i  (wrap_d),
      .q_o  (wrap_q)
   );

   assign count = count_q;
   assign Wrap  = wrap_q;
   assign Tc    = En & (((Up == DIR_UP) & at_max) | ((Up == DIR_DOWN) & at_zero));

endmodule

// File: tb/tb_param_updown_mod_counter.sv
// Self-checking bench: five counter builds share stimulus, a reference model
// pushes expected results per edge into a scoreboard queue.
module tb_param_updown_mod_counter;

   localparam int N = 5;
   localparam int WID [N] = '{4, 4, 4, 3, 1};
   localparam int MODS[N] = '{10, 10, 10, 8, 2};
   localparam int RVS [N] = '{0, 0, 3, 0, 0};
   localparam int SATS[N] = '{0, 1, 0, 0, 0};

   typedef struct packed {
      logic [N-1:0][3:0] cnt;
      logic [N-1:0]      wr;
   } exp_t;

   logic       Clk = 1'b0;
   logic       Clr, En, Up, Load;
   logic [3:0] LoadVal;

   logic [3:0] c0, c1, c2;
   logic [2:0] c3;
   logic       c4;
   logic [N-1:0]      obs_tc, obs_wr;
   logic [N-1:0][3:0] obs_cnt;

   int total = 0;
   int bad   = 0;
   exp_t sb_q[$];
   int  mc[N];

   always #5 Clk = ~Clk;

   param_updown_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0), .SATURATE(0)) u0 (
      .Clk(Clk), .Clr(Clr), .En(En), .Up(Up), .Load(Load), .LoadVal(LoadVal),
      .count(c0), .Tc(obs_tc[0]), .Wrap(obs_wr[0]));
   param_updown_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0), .SATURATE(1)) u1 (
      .Clk(Clk), .Clr(Clr), .En(En), .Up(Up), .Load(Load), .LoadVal(LoadVal),
      .count(c1), .Tc(obs_tc[1]), .Wrap(obs_wr[1]));
   param_updown_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(3), .SATURATE(0)) u2 (
      .Clk(Clk), .Clr(Clr), .En(En), .Up(Up), .Load(Load), .LoadVal(LoadVal),
      .count(c2), .Tc(obs_tc[2]), .Wrap(obs_wr[2]));
   param_updown_mod_counter #(.WIDTH(3), .MODULUS(8), .RESET_VALUE(0), .SATURATE(0)) u3 (
      .Clk(Clk), .Clr(Clr), .En(En), .Up(Up), .Load(Load), .LoadVal(LoadVal[2:0]),
      .count(c3), .Tc(obs_tc[3]), .Wrap(obs_wr[3]));
   param_updown_mod_counter #(.WIDTH(1), .MODULUS(2), .RESET_VALUE(0), .SATURATE(0)) u4 (
      .Clk(Clk), .Clr(Clr), .En(En), .Up(Up), .Load(Load), .LoadVal(LoadVal[0:0]),
      .count(c4), .Tc(obs_tc[4]), .Wrap(obs_wr[4]));

   assign obs_cnt[0] = c0;
   assign obs_cnt[1] = c1;
   assign obs_cnt[2] = c2;
   assign obs_cnt[3] = {1'b0, c3};
   assign obs_cnt[4] = {3'b0, c4};

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference behaviour of one counter for one clock edge.
   function automatic void model_step(input int md, input int sat, input int rv, input int cur,
                                      input bit clr, input bit load, input int lv,
                                      input bit en, input bit up,
                                      output int nxt, output int wr);
      nxt = cur;
      wr  = 0;
      if (clr) nxt = rv;
      else if (load) nxt = (lv < md) ? lv : md - 1;
      else if (en) begin
         if (up) begin
            if (cur == md - 1) begin
               if (sat == 0) begin nxt = 0; wr = 1; end
            end else nxt = cur + 1;
         end else begin
            if (cur == 0) begin
               if (sat == 0) begin nxt = md - 1; wr = 1; end
            end else nxt = cur - 1;
         end
      end
   endfunction

   // Drive one cycle of stimulus, check Tc, push expectation, then compare after the edge.
   task automatic step(input bit clr, input bit load, input int lv, input bit en, input bit up,
                       input bit check_tc);
      exp_t e, got;
      int nxt, wr, lvm;
      @(negedge Clk);
      Clr = clr; Load = load; LoadVal = 4'(lv); En = en; Up = up;
      #1;
      for (int i = 0; i < N; i++) begin
         if (check_tc) begin
            bit tc;
            tc = en && ((up && mc[i] == MODS[i] - 1) || (!up && mc[i] == 0));
            check_val($sformatf("tc[%0d] cnt=%0d", i, mc[i]), 32'(obs_tc[i]), 32'(tc));
         end
         lvm = (lv & 15) & ((1 << WID[i]) - 1);
         model_step(MODS[i], SATS[i], RVS[i], mc[i], clr, load, lvm, en, up, nxt, wr);
         e.cnt[i] = 4'(nxt);
         e.wr[i]  = 1'(wr);
         mc[i]    = nxt;
      end
      sb_q.push_back(e);
      @(posedge Clk);
      #1;
      got = sb_q.pop_front();
      for (int i = 0; i < N; i++) begin
         check_val($sformatf("count[%0d]", i), 32'(obs_cnt[i]), 32'(got.cnt[i]));
         check_val($sformatf("wrap[%0d]", i), 32'(obs_wr[i]), 32'(got.wr[i]));
      end
   endtask

   initial begin
      Clr = 1'b0; Load = 1'b0; LoadVal = '0; En = 1'b0; Up = 1'b1;
      for (int i = 0; i < N; i++) mc[i] = 0;

      // Reset, then 12 up-counts (wrap at 9 -> 0)
      step(1, 0, 0, 0, 1, 0);
      for (int k = 0; k < 12; k++) step(0, 0, 0, 1, 1, 1);

      // Down from 0: wrap to MODULUS-1 then descend
      step(0, 1, 0, 0, 1, 1);
      for (int k = 0; k < 12; k++) step(0, 0, 0, 1, 0, 1);

      // Hold with En low
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, k[0], 1);

      // Loads: in range, clamp, load over terminal count
      step(0, 1, 6, 0, 1, 1);
      step(0, 1, 13, 0, 1, 1);
      step(0, 1, 9, 0, 1, 1);
      step(0, 1, 4, 1, 1, 1);
      step(0, 1, 15, 1, 0, 1);

      // Saturation run from 7, then reverse
      step(0, 1, 7, 0, 1, 1);
      for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 1, 1);
      step(0, 0, 0, 1, 0, 1);

      // Clr beats Load and a pending wrap
      step(0, 1, 9, 0, 1, 1);
      step(1, 1, 5, 1, 1, 1);
      step(0, 0, 0, 1, 1, 1);

      // Continuous up-count across all builds
      for (int k = 0; k < 20; k++) step(0, 0, 0, 1, 1, 1);

      // Random mix
      for (int k = 0; k < 80; k++) begin
         bit rc, rl, re, ru;
         rc = ($urandom_range(0, 19) == 0);
         rl = ($urandom_range(0, 7) == 0);
         re = ($urandom_range(0, 3) != 0);
         ru = 1'($urandom_range(0, 1));
         step(rc, rl, int'($urandom_range(0, 15)), re, ru, 1);
      end

      check_val("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
